uart_rx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_byte.sv | 131 +++++++++++++
 rtl/uart_rx_frame.sv | 121 ++++++++++++
 tb/tb_uart_rx_frame.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and default bit timing.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 104;  // 12 MHz / 115200

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Counter width able to hold values 0..count-1, never narrower than 1 bit.
    function automatic int cnt_width(input int count);
        return (count > 2) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, start/data/stop/break FSM and mid-bit sampling.
// stop_ok/stop_bad are combinational strobes one cycle ahead of byte_valid/frame_err.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] byte_out,
    output logic                      byte_valid,
    output logic                      frame_err,
    output logic                      stop_ok,
    output logic                      stop_bad,
    output logic [UART_DATA_BITS-1:0] shift_data,
    output logic                      line_idle
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(UART_DATA_BITS - 1);

    logic                      sync1_reg;
    logic                      rxs_reg;
    rx_state_t                 state_reg;
    rx_state_t                 state_next;
    logic [CNT_W-1:0]          clk_cnt_reg;
    logic [2:0]                bit_idx_reg;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] byte_reg;
    logic                      byte_valid_reg;
    logic                      frame_err_reg;
    logic                      half_hit;
    logic                      full_hit;
    logic                      sample_bit;

    // rx is asynchronous; presetting to 1 keeps reset from looking like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            rxs_reg   <= 1'b1;
        end else begin
            sync1_reg <= rx;
            rxs_reg   <= sync1_reg;
        end
    end

    assign half_hit = (clk_cnt_reg == HALF_LAST);
    assign full_hit = (clk_cnt_reg == FULL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!rxs_reg) state_next = START;
            START:   if (half_hit) state_next = rxs_reg ? IDLE : DATA;
            DATA:    if (full_hit && bit_idx_reg == LAST_BIT) state_next = STOP;
            STOP:    if (full_hit) state_next = rxs_reg ? IDLE : BREAK;
            BREAK:   if (rxs_reg) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stop_ok    = 1'b0;
        stop_bad   = 1'b0;
        sample_bit = 1'b0;
        line_idle  = 1'b0;
        case (state_reg)
            IDLE: line_idle  = 1'b1;
            DATA: sample_bit = full_hit;
            STOP: begin
                stop_ok  = full_hit && rxs_reg;
                stop_bad = full_hit && !rxs_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_reg    <= '0;
            bit_idx_reg    <= '0;
            shift_reg      <= '0;
            byte_reg       <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            byte_valid_reg <= stop_ok;
            frame_err_reg  <= stop_bad;
            if (stop_ok) begin
                byte_reg <= shift_reg;
            end
            // LSB arrives first, so shift right and enter at the top.
            if (sample_bit) begin
                shift_reg <= {rxs_reg, shift_reg[UART_DATA_BITS-1:1]};
            end
            case (state_reg)
                START: begin
                    bit_idx_reg <= '0;
                    clk_cnt_reg <= half_hit ? '0 : clk_cnt_reg + 1'b1;
                end
                DATA: begin
                    if (full_hit) begin
                        clk_cnt_reg <= '0;
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                    end else begin
                        clk_cnt_reg <= clk_cnt_reg + 1'b1;
                    end
                end
                STOP:    clk_cnt_reg <= full_hit ? '0 : clk_cnt_reg + 1'b1;
                default: clk_cnt_reg <= '0;
            endcase
        end
    end

    assign byte_out   = byte_reg;
    assign byte_valid = byte_valid_reg;
    assign frame_err  = frame_err_reg;
    assign shift_data = shift_reg;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive path: assembles FRAME_BYTES received bytes into one word, byte 0 lowest.
// Define UART_RX_TIMEOUT_EN to drop a partial word after TIMEOUT_BITS idle bit-times.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FRAME_BYTES  = 4,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                rx,
    output logic [UART_DATA_BITS-1:0]           byte_out,
    output logic                                byte_valid,
    output logic [UART_DATA_BITS*FRAME_BYTES-1:0] data_out,
    output logic                                data_valid,
    output logic                                frame_err,
    output logic                                frame_timeout
);

    localparam int IDX_W = cnt_width(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    if (CLKS_PER_BIT < 8 || FRAME_BYTES < 1 || TIMEOUT_BITS < 1) begin : g_bad_cfg
        $error("uart_rx_frame: unsupported parameter combination");
    end

    logic                      stop_ok;
    logic                      stop_bad;
    logic                      line_idle;
    logic                      timeout_hit;
    logic [UART_DATA_BITS-1:0] shift_data;
    logic [IDX_W-1:0]          idx_reg;
    logic [IDX_W-1:0]          idx_next;
    logic                      data_valid_reg;
    logic [UART_DATA_BITS-1:0] lane_reg [FRAME_BYTES];

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx_byte (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .stop_ok    (stop_ok),
        .stop_bad   (stop_bad),
        .shift_data (shift_data),
        .line_idle  (line_idle)
    );

    // Lanes load on the same edge as byte_out, so the word is complete alongside the last byte_valid.
    for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (rst) begin
                lane_reg[gi] <= '0;
            end else if (stop_ok && idx_reg == IDX_W'(gi)) begin
                lane_reg[gi] <= shift_data;
            end
        end
        assign data_out[UART_DATA_BITS*gi +: UART_DATA_BITS] = lane_reg[gi];
    end

    always_comb begin
        idx_next = idx_reg;
        if (stop_bad) begin
            idx_next = '0;
        end else if (stop_ok) begin
            idx_next = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
        end else if (timeout_hit) begin
            idx_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_reg        <= '0;
            data_valid_reg <= 1'b0;
        end else begin
            idx_reg        <= idx_next;
            data_valid_reg <= stop_ok && (idx_reg == LAST_IDX);
        end
    end

    assign data_valid = data_valid_reg;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] idle_cnt_reg;
    logic            frame_timeout_reg;

    // Only a partially filled word ages; any start detection leaves IDLE and clears the count.
    assign timeout_hit = line_idle && (idx_reg != '0) && (idle_cnt_reg == TO_W'(TO_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt_reg      <= '0;
            frame_timeout_reg <= 1'b0;
        end else begin
            frame_timeout_reg <= timeout_hit;
            if (!line_idle || idx_reg == '0 || timeout_hit) begin
                idle_cnt_reg <= '0;
            end else begin
                idle_cnt_reg <= idle_cnt_reg + 1'b1;
            end
        end
    end

    assign frame_timeout = frame_timeout_reg;
`else
    logic unused_line_idle;

    assign unused_line_idle = line_idle;
    assign timeout_hit      = 1'b0;
    assign frame_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit: table of good frames plus corner sequences.
module tb_uart_rx_frame;

    localparam int CPB = 16;
    localparam int FB  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [31:0] data_out;
    logic        data_valid;
    logic        frame_err;
    logic        frame_timeout;

    int compared   = 0;
    int mismatched = 0;

    int n_bv       = 0;
    int n_dv       = 0;
    int n_fe       = 0;
    int n_to       = 0;
    int n_dv_alone = 0;
    logic [7:0]  last_byte = '0;
    logic [31:0] last_word = '0;

    typedef struct {
        logic [31:0] word;
        int          exp_bytes;
        int          exp_words;
        logic [31:0] exp_data;
        logic [7:0]  exp_last_byte;
    } vec_t;

    always #5 clk = ~clk;

    uart_rx_frame #(
        .CLKS_PER_BIT(CPB),
        .FRAME_BYTES (FB),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_err    (frame_err),
        .frame_timeout(frame_timeout)
    );

    always @(negedge clk) begin
        if (byte_valid) begin
            n_bv      <= n_bv + 1;
            last_byte <= byte_out;
        end
        if (data_valid) begin
            n_dv      <= n_dv + 1;
            last_word <= data_out;
            if (!byte_valid) n_dv_alone <= n_dv_alone + 1;
        end
        if (frame_err)     n_fe <= n_fe + 1;
        if (frame_timeout) n_to <= n_to + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        rx = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < FB; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [4];
        int b_bv, b_dv, b_fe, b_to, b_alone;

        vecs[0] = '{word: 32'h1234_5678, exp_bytes: 4, exp_words: 1, exp_data: 32'h1234_5678, exp_last_byte: 8'h12};
        vecs[1] = '{word: 32'hCAFE_F00D, exp_bytes: 4, exp_words: 1, exp_data: 32'hCAFE_F00D, exp_last_byte: 8'hCA};
        vecs[2] = '{word: 32'h00FF_00FF, exp_bytes: 4, exp_words: 1, exp_data: 32'h00FF_00FF, exp_last_byte: 8'h00};
        vecs[3] = '{word: 32'h8000_0001, exp_bytes: 4, exp_words: 1, exp_data: 32'h8000_0001, exp_last_byte: 8'h80};

        // Reset state
        repeat (4) @(negedge clk);
        check("reset byte_out", {24'h0, byte_out}, 32'h0);
        check("reset data_out", data_out, 32'h0);
        check("reset pulses", {28'h0, byte_valid, data_valid, frame_err, frame_timeout}, 32'h0);
        rst = 1'b0;
        idle_bits(2);

        // Good frames, back-to-back bytes with one stop bit
        for (int v = 0; v < 4; v++) begin
            b_bv = n_bv; b_dv = n_dv; b_alone = n_dv_alone; b_fe = n_fe;
            send_word(vecs[v].word);
            idle_bits(2);
            check($sformatf("vec%0d byte_valid count", v), n_bv - b_bv, vecs[v].exp_bytes);
            check($sformatf("vec%0d data_valid count", v), n_dv - b_dv, vecs[v].exp_words);
            check($sformatf("vec%0d data_out", v), last_word, vecs[v].exp_data);
            check($sformatf("vec%0d last byte_out", v), {24'h0, last_byte}, {24'h0, vecs[v].exp_last_byte});
            check($sformatf("vec%0d data_valid w/o byte_valid", v), n_dv_alone - b_alone, 0);
            check($sformatf("vec%0d frame_err count", v), n_fe - b_fe, 0);
        end

        // Bad stop bit, then a fresh word
        b_bv = n_bv; b_fe = n_fe;
        send_byte(8'h55, 1'b0);
        idle_bits(2);
        check("badstop frame_err count", n_fe - b_fe, 1);
        check("badstop byte_valid count", n_bv - b_bv, 0);
        b_dv = n_dv;
        send_word(32'hDEAD_BEEF);
        idle_bits(2);
        check("after badstop data_valid count", n_dv - b_dv, 1);
        check("after badstop data_out", last_word, 32'hDEAD_BEEF);

        // Short glitch on the line
        b_bv = n_bv; b_fe = n_fe; b_dv = n_dv;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle_bits(2);
        check("glitch pulses", (n_bv - b_bv) + (n_fe - b_fe) + (n_dv - b_dv), 0);
        send_byte(8'hA5, 1'b1);
        idle_bits(2);
        check("after glitch byte count", n_bv - b_bv, 1);
        check("after glitch byte_out", {24'h0, last_byte}, 32'h0000_00A5);

        // Reset in the middle of the second data bit
        b_bv = n_bv; b_fe = n_fe; b_dv = n_dv;
        bit_time(1'b0);
        bit_time(1'b1);
        rx = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        @(negedge clk);
        check("midreset byte_out", {24'h0, byte_out}, 32'h0);
        check("midreset data_out", data_out, 32'h0);
        check("midreset pulses", {28'h0, byte_valid, data_valid, frame_err, frame_timeout}, 32'h0);
        rst = 1'b0;
        idle_bits(3);
        check("midreset no reports", (n_bv - b_bv) + (n_fe - b_fe) + (n_dv - b_dv), 0);
        send_word(32'h1122_3344);
        idle_bits(2);
        check("after midreset data_valid count", n_dv - b_dv, 1);
        check("after midreset data_out", last_word, 32'h1122_3344);

        // Break: line held low for 40 bit-times
        b_bv = n_bv; b_fe = n_fe;
        rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        idle_bits(2);
        check("break frame_err count", n_fe - b_fe, 1);
        check("break byte_valid count", n_bv - b_bv, 0);
        send_byte(8'h3C, 1'b1);
        idle_bits(2);
        check("after break byte count", n_bv - b_bv, 1);
        check("after break byte_out", {24'h0, last_byte}, 32'h0000_003C);

        // Partial frame left idle, then a full word
        pulse_reset();
        idle_bits(2);
        b_dv = n_dv; b_to = n_to;
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        idle_bits(22);
        send_word(32'h0403_0201);
        idle_bits(2);
        check("stale frame data_valid count", n_dv - b_dv, 1);
`ifdef UART_RX_TIMEOUT_EN
        check("timeout pulse count", n_to - b_to, 1);
        check("stale frame data_out", last_word, 32'h0403_0201);
`else
        check("timeout pulse count", n_to - b_to, 0);
        check("stale frame data_out", last_word, 32'h0201_0403);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
